// File: rtl/alu_share_sched.sv
// Two-requester round-robin scheduler that time-shares one external single-cycle ALU.
// Each operation takes accept, execute and respond cycles. Results return with the owner ID.
module alu_share_sched #(
  parameter int W    = 32,
  parameter int OPW  = 10,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [W-1:0]    req0_v1,
  input  logic [W-1:0]    req0_v2,
  input  logic [W-1:0]    req1_v1,
  input  logic [W-1:0]    req1_v2,
  input  logic [OPW-1:0]  req0_op,
  input  logic [OPW-1:0]  req1_op,
  output logic [W-1:0]    alu_v1,
  output logic [W-1:0]    alu_v2,
  output logic [OPW-1:0]  alu_op,
  input  logic [W-1:0]    alu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_err,
  output logic [CNTW-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          r_state, w_state_next;
  logic            r_last_grant;
  logic            r_id;
  logic [W-1:0]    r_v1, r_v2;
  logic [OPW-1:0]  r_op;
  logic [W-1:0]    r_rsp_data;
  logic            r_rsp_err;
  logic [CNTW-1:0] r_done_cnt;
  logic            w_grant0, w_grant1;
  logic            w_op_err;

  // An op is illegal unless exactly one bit is set; zero counts as illegal.
  assign w_op_err = (r_op == '0) || ((r_op & (r_op - OPW'(1))) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    alu_op       = '0;
    case (r_state)
      IDLE: begin
        // Requester 0 wins a tie only when requester 1 had the previous grant.
        if (req0_valid && (!req1_valid || r_last_grant)) w_grant0 = 1'b1;
        else if (req1_valid)                             w_grant1 = 1'b1;
        if (w_grant0 || w_grant1) w_state_next = EXEC;
      end
      EXEC: begin
        alu_op       = r_op;
        w_state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_v1         <= '0;
      r_v2         <= '0;
      r_op         <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_done_cnt   <= '0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_v1         <= w_grant1 ? req1_v1 : req0_v1;
        r_v2         <= w_grant1 ? req1_v2 : req0_v2;
        r_op         <= w_grant1 ? req1_op : req0_op;
        r_last_grant <= w_grant1;
        r_id         <= w_grant1;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_op_err ? '0 : alu_result;
        r_rsp_err  <= w_op_err;
      end
      if (r_state == RESP && rsp_ready) r_done_cnt <= r_done_cnt + CNTW'(1);
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign alu_v1     = r_v1;
  assign alu_v2     = r_v2;
  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_alu_share_sched.sv
// Bench for alu_share_sched: directed vector table, random traffic against a reference model,
// plus hand-written reset-mid-op and continuous-tie sequences. Counter width reduced so it wraps.
module tb_alu_share_sched;
  localparam int W    = 32;
  localparam int OPW  = 10;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [W-1:0]    req0_v1 = '0, req0_v2 = '0, req1_v1 = '0, req1_v2 = '0;
  logic [OPW-1:0]  req0_op = '0, req1_op = '0;
  logic [W-1:0]    alu_v1, alu_v2, alu_result;
  logic [OPW-1:0]  alu_op;
  logic            rsp_valid, rsp_id, rsp_err;
  logic            rsp_ready = 1'b0;
  logic [W-1:0]    rsp_data;
  logic [CNTW-1:0] done_cnt;

  always #5 clk = ~clk;

  alu_share_sched #(.W(W), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_v1(req0_v1), .req0_v2(req0_v2), .req1_v1(req1_v1), .req1_v2(req1_v2),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .done_cnt(done_cnt)
  );

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OPW-1:0] op);
    case (op)
      10'h001: return a + b;
      10'h002: return a - b;
      10'h004: return a ^ b;
      10'h008: return a | b;
      10'h010: return a & b;
      10'h020: return a << b[4:0];
      10'h040: return a >> b[4:0];
      10'h080: return $signed(a) >>> b[4:0];
      10'h100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      10'h200: return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  // External ALU stand-in; emits garbage on multi-hot ops so the error forcing is visible.
  always_comb begin
    if ($countones(alu_op) == 1) alu_result = ref_alu(alu_v1, alu_v2, alu_op);
    else if (alu_op == '0)       alu_result = '0;
    else                         alu_result = 32'hBAD0_BAD0;
  end

  typedef struct {
    bit             va, vb;
    logic [W-1:0]   a1, a2, b1, b2;
    logic [OPW-1:0] aop, bop;
    int             stall;
    bit             exp_id;
    logic [W-1:0]   exp_data;
    bit             exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit m_last = 1'b1;
  int m_done = 0;
  int completions = 0;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit va, input bit vb, input logic [W-1:0] a1, a2, b1, b2,
                              input logic [OPW-1:0] aop, bop, input int stall);
    vec_t v;
    logic [OPW-1:0] op;
    v.va = va; v.vb = vb; v.a1 = a1; v.a2 = a2; v.b1 = b1; v.b2 = b2;
    v.aop = aop; v.bop = bop; v.stall = stall;
    v.exp_id = (va && vb) ? !m_last : vb;
    op = v.exp_id ? bop : aop;
    v.exp_err = ($countones(op) != 1);
    v.exp_data = v.exp_err ? '0 : (v.exp_id ? ref_alu(b1, b2, bop) : ref_alu(a1, a2, aop));
    return v;
  endfunction

  function automatic logic [OPW-1:0] rand_op();
    int r;
    r = $urandom_range(0, 11);
    if (r < 10)  return OPW'(1) << r;
    if (r == 10) return '0;
    return OPW'($urandom);
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge that starts the next idle cycle.
  task automatic issue(input vec_t v);
    bit g;
    req0_valid = v.va; req0_v1 = v.a1; req0_v2 = v.a2; req0_op = v.aop;
    req1_valid = v.vb; req1_v1 = v.b1; req1_v2 = v.b2; req1_op = v.bop;
    rsp_ready = 1'b0;
    #1;
    if (!v.va && !v.vb) begin
      chk("idle_ready0", req0_ready, 0);
      chk("idle_ready1", req1_ready, 0);
      @(negedge clk);
      return;
    end
    g = (v.va && v.vb) ? !m_last : v.vb;
    chk("grant_ready0", req0_ready, !g);
    chk("grant_ready1", req1_ready, g);
    m_last = g;
    @(negedge clk);
    chk("exec_alu_op", alu_op, g ? v.bop : v.aop);
    chk("exec_alu_v1", alu_v1, g ? v.b1 : v.a1);
    chk("exec_alu_v2", alu_v2, g ? v.b2 : v.a2);
    chk("exec_ready", {req0_ready, req1_ready}, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    for (int i = 0; i <= v.stall; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, v.exp_id);
      chk("rsp_data", rsp_data, v.exp_data);
      chk("rsp_err", rsp_err, v.exp_err);
      chk("rsp_ready_outs", {req0_ready, req1_ready}, 0);
      chk("rsp_alu_op_idle", alu_op, 0);
      chk("rsp_done_hold", done_cnt, m_done);
      if (i < v.stall) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    m_done = (m_done + 1) % (1 << CNTW);
    completions++;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("done_cnt", done_cnt, m_done);
    $display("txn id=%0d data=%h err=%0d stall=%0d done_cnt=%0d",
             v.exp_id, v.exp_data, v.exp_err, v.stall, done_cnt);
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    //          va vb a1            a2  b1            b2   aop      bop      st id data           err
    tbl[0]  = '{1, 1, 10,           3,  1,            4,   10'h002, 10'h020, 0, 0, 7,             0};
    tbl[1]  = '{1, 1, 10,           3,  1,            4,   10'h002, 10'h020, 0, 1, 16,            0};
    tbl[2]  = '{1, 0, 5,            7,  0,            0,   10'h001, 10'h000, 5, 0, 12,            0};
    tbl[3]  = '{0, 1, 0,            0,  9,            4,   10'h000, 10'h003, 0, 1, 0,             1};
    tbl[4]  = '{0, 1, 0,            0,  9,            4,   10'h000, 10'h000, 0, 1, 0,             1};
    tbl[5]  = '{0, 1, 0,            0,  32'hF0,       32'hFF, 10'h000, 10'h004, 0, 1, 32'h0F,  0};
    tbl[6]  = '{1, 0, 32'h8000_0000, 4, 0,            0,   10'h080, 10'h000, 1, 0, 32'hF800_0000, 0};
    tbl[7]  = '{0, 1, 0,            0,  32'hFFFF_FFFF, 1,  10'h000, 10'h100, 0, 1, 1,             0};
    tbl[8]  = '{1, 0, 32'hFFFF_FFFF, 1, 0,            0,   10'h200, 10'h000, 0, 0, 0,             0};
    tbl[9]  = '{1, 0, 32'h8000_0000, 4, 0,            0,   10'h040, 10'h000, 0, 0, 32'h0800_0000, 0};
    tbl[10] = '{1, 1, 32'hF0,       32'h0F, 32'hFF,   32'h0F, 10'h008, 10'h010, 0, 1, 32'h0F,   0};
    tbl[11] = '{1, 1, 32'hF0,       32'h0F, 32'hFF,   32'h0F, 10'h008, 10'h010, 2, 0, 32'hFF,   0};

    #2;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_done_cnt", done_cnt, 0);
    chk("reset_alu_v1", alu_v1, 0);
    chk("reset_alu_v2", alu_v2, 0);
    chk("reset_alu_op", alu_op, 0);
    chk("reset_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) issue(tbl[i]);
    clear_reqs();

    for (int i = 0; i < 200 && (i < 30 || completions < 40); i++) begin
      vec_t v;
      v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom, $urandom, $urandom, $urandom, rand_op(), rand_op(),
             $urandom_range(0, 2));
      issue(v);
    end
    clear_reqs();

    // Reset during EXEC drops the in-flight op.
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    req0_valid = 1'b1; req0_v1 = 32'h1234; req0_v2 = 32'h1; req0_op = 10'h001;
    #1;
    chk("midrst_grant", req0_ready, 1);
    @(negedge clk);
    chk("midrst_exec_op", alu_op, 10'h001);
    #2;
    rst_n = 1'b0;
    clear_reqs();
    #1;
    chk("midrst_alu_op", alu_op, 0);
    chk("midrst_alu_v1", alu_v1, 0);
    chk("midrst_alu_v2", alu_v2, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_done_cnt", done_cnt, 0);
    chk("midrst_ready", {req0_ready, req1_ready}, 0);
    m_last = 1'b1;
    m_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_no_rsp", rsp_valid, 0);
    end

    // Continuous tie after reset: requester 0 first, then strict alternation.
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      logic [W-1:0] a, b;
      a = $urandom; b = $urandom;
      v = '{1, 1, a, b, b, a, 10'h001, 10'h002, 0, 1'(i % 2),
            (i % 2) ? (b - a) : (a + b), 0};
      issue(v);
    end
    clear_reqs();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
